discharge_pulse_sequencer: RTL and testbench

Sequences one discharge pulse through breakdown wait, buck-interleave discharge and de-ionisation, and drives the buck switch per switching period. It publishes the look-ahead period index `timer_cycle_num` to the open-loop charging-time generator. It then consumes that generator's `inductor_charging_time` as the per-period on-time. It sits between the discharge enable from the machining supervisor and the gate driver of the buck stage.

---
 rtl/discharge_ctrl_pkg.sv | 14 +
 rtl/buck_pwm_period.sv | 47 ++++
 rtl/discharge_pulse_sequencer.sv | 139 +++++++++++++
 tb/tb_discharge_pulse_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/discharge_ctrl_pkg.sv
// Shared definitions for the discharge pulse control path: state codes and field widths.
package discharge_ctrl_pkg;

    localparam int STATE_W = 8;
    localparam int TIME_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE            = 8'h00,
        S_WAIT_BREAKDOWN  = 8'h01,
        S_BUCK_INTERLEAVE = 8'h02,
        S_DEION           = 8'h80
    } state_t;

endpackage

// File: rtl/buck_pwm_period.sv
// One buck switching period: period counter, on-time latch at each period start, registered gate.
module buck_pwm_period
    import discharge_ctrl_pkg::*;
#(
    parameter logic [TIME_W-1:0] CYCLE_PERIOD = 16'd200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [TIME_W-1:0] on_time,
    output logic              period_start,
    output logic              period_end,
    output logic              gate
);

    localparam logic [TIME_W-1:0] LAST_PC = CYCLE_PERIOD - 16'd1;

    logic [TIME_W-1:0] pc_reg;
    logic [TIME_W-1:0] ton_reg;
    logic              running_reg;
    logic              gate_reg;

    assign period_end   = running_reg && (pc_reg == LAST_PC);
    // The first enabled edge starts a period just like a wrap does.
    assign period_start = enable && (!running_reg || period_end);
    assign gate         = gate_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            pc_reg      <= '0;
            ton_reg     <= '0;
            running_reg <= 1'b0;
            gate_reg    <= 1'b0;
        end else begin
            running_reg <= 1'b1;
            if (period_start) begin
                pc_reg   <= '0;
                ton_reg  <= on_time;
                gate_reg <= (on_time != '0);
            end else begin
                pc_reg   <= pc_reg + 16'd1;
                gate_reg <= ((pc_reg + 16'd1) < ton_reg);
            end
        end
    end

endmodule

// File: rtl/discharge_pulse_sequencer.sv
// Sequences one discharge pulse: breakdown wait, interleaved buck discharge, de-ionisation.
module discharge_pulse_sequencer
    import discharge_ctrl_pkg::*;
#(
    parameter logic [TIME_W-1:0] CYCLE_PERIOD      = 16'd200,
    parameter logic [TIME_W-1:0] MIN_OFF_TIME      = 16'd10,
    parameter logic [TIME_W-1:0] DISCHARGE_CYCLES  = 16'd50,
    parameter logic [TIME_W-1:0] DEION_TIME        = 16'd1000,
    parameter logic [TIME_W-1:0] BREAKDOWN_TIMEOUT = 16'd20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               discharge_en,
    input  logic               breakdown_detected,
    input  logic [TIME_W-1:0]  inductor_charging_time,
    output logic [TIME_W-1:0]  timer_cycle_num,
    output logic               buck_gate,
    output logic               voltage_on,
    output logic [STATE_W-1:0] state,
    output logic               pulse_done,
    output logic               open_circuit_timeout
);

    localparam logic [TIME_W-1:0] ON_MAX       = CYCLE_PERIOD - MIN_OFF_TIME;
    localparam logic [TIME_W-1:0] TIMEOUT_LAST = BREAKDOWN_TIMEOUT - 16'd1;
    localparam logic [TIME_W-1:0] DEION_LAST   = DEION_TIME - 16'd1;

    state_t            state_reg;
    logic [TIME_W-1:0] cnt_reg;
    logic [TIME_W-1:0] tcn_reg;
    logic              voltage_on_reg;
    logic              pulse_done_reg;
    logic              timeout_reg;
    logic              complete_reg;

    logic [TIME_W-1:0] on_time_clamped;
    logic              last_period;
    logic              buck_enable;
    logic              period_start;
    logic              period_end;

    assign last_period = (tcn_reg == DISCHARGE_CYCLES);

    // buck_enable is the "in BUCK after this edge" decision, so the PWM block
    // starts its first period on the very edge that sees breakdown.
    always_comb begin
        on_time_clamped = (inductor_charging_time > ON_MAX) ? ON_MAX : inductor_charging_time;
        buck_enable     = 1'b0;
        case (state_reg)
            S_WAIT_BREAKDOWN:  buck_enable = breakdown_detected;
            S_BUCK_INTERLEAVE: buck_enable = !(period_end && (last_period || !discharge_en));
            default:           buck_enable = 1'b0;
        endcase
    end

    buck_pwm_period #(
        .CYCLE_PERIOD (CYCLE_PERIOD)
    ) u_pwm (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (buck_enable),
        .on_time      (on_time_clamped),
        .period_start (period_start),
        .period_end   (period_end),
        .gate         (buck_gate)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            tcn_reg        <= '0;
            voltage_on_reg <= 1'b0;
            pulse_done_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            complete_reg   <= 1'b0;
        end else begin
            pulse_done_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            if (period_start && (tcn_reg != 16'hFFFF)) begin
                tcn_reg <= tcn_reg + 16'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (discharge_en) begin
                        state_reg      <= S_WAIT_BREAKDOWN;
                        voltage_on_reg <= 1'b1;
                        cnt_reg        <= '0;
                    end
                end
                S_WAIT_BREAKDOWN: begin
                    if (breakdown_detected) begin
                        state_reg      <= S_BUCK_INTERLEAVE;
                        voltage_on_reg <= 1'b0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg      <= S_DEION;
                        voltage_on_reg <= 1'b0;
                        timeout_reg    <= 1'b1;
                        complete_reg   <= 1'b0;
                        cnt_reg        <= '0;
                    end else if (!discharge_en) begin
                        state_reg      <= S_DEION;
                        voltage_on_reg <= 1'b0;
                        complete_reg   <= 1'b0;
                        cnt_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                S_BUCK_INTERLEAVE: begin
                    if (!buck_enable) begin
                        state_reg    <= S_DEION;
                        complete_reg <= last_period;
                        cnt_reg      <= '0;
                    end
                end
                S_DEION: begin
                    if (cnt_reg == DEION_LAST) begin
                        state_reg      <= discharge_en ? S_WAIT_BREAKDOWN : S_IDLE;
                        voltage_on_reg <= discharge_en;
                        pulse_done_reg <= complete_reg;
                        tcn_reg        <= '0;
                        cnt_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign timer_cycle_num      = tcn_reg;
    assign voltage_on           = voltage_on_reg;
    assign state                = state_reg;
    assign pulse_done           = pulse_done_reg;
    assign open_circuit_timeout = timeout_reg;

endmodule

// File: tb/tb_discharge_pulse_sequencer.sv
// Directed bench for discharge_pulse_sequencer with a registered open-loop charging-time generator.
module tb_discharge_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        discharge_en;
    logic        breakdown_detected;
    logic [15:0] inductor_charging_time = 16'd0;
    logic [15:0] timer_cycle_num;
    logic        buck_gate;
    logic        voltage_on;
    logic [7:0]  state;
    logic        pulse_done;
    logic        open_circuit_timeout;

    logic        gen_const_en = 1'b0;
    logic [15:0] gen_const    = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_w, bad, buck_clks, n;
    bit pd_seen, oc_seen;

    discharge_pulse_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .discharge_en           (discharge_en),
        .breakdown_detected     (breakdown_detected),
        .inductor_charging_time (inductor_charging_time),
        .timer_cycle_num        (timer_cycle_num),
        .buck_gate              (buck_gate),
        .voltage_on             (voltage_on),
        .state                  (state),
        .pulse_done             (pulse_done),
        .open_circuit_timeout   (open_circuit_timeout)
    );

    always #5 clk = ~clk;

    // Open-loop generator: 120 clocks for look-ahead index 0..2, then 80; one clock of latency.
    always @(posedge clk) begin
        if (gen_const_en) inductor_charging_time <= gen_const;
        else              inductor_charging_time <= (timer_cycle_num < 16'd3) ? 16'd120 : 16'd80;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_deion(output int cnt, output bit pd);
        cnt = 0;
        pd  = 1'b0;
        while (state == 8'h80 && cnt < 1100) begin
            tick();
            cnt++;
            if (pulse_done) pd = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        discharge_en = 1'b0;
        breakdown_detected = 1'b0;
        tick(); tick(); tick();
        chk("rst_state", state, 8'h00);
        chk("rst_gate", buck_gate, 0);
        chk("rst_voltage", voltage_on, 0);
        chk("rst_tcn", timer_cycle_num, 0);
        chk("rst_pulse_done", pulse_done, 0);
        chk("rst_timeout", open_circuit_timeout, 0);

        // Nominal pulse
        rst_n = 1'b1;
        tick();
        chk("idle_state", state, 8'h00);
        discharge_en = 1'b1;
        tick();
        chk("en_state", state, 8'h01);
        chk("en_voltage", voltage_on, 1);
        chk("en_tcn", timer_cycle_num, 0);
        repeat (4) tick();
        breakdown_detected = 1'b1;
        tick();
        breakdown_detected = 1'b0;
        chk("bd_state", state, 8'h02);
        chk("bd_gate", buck_gate, 1);
        chk("bd_voltage", voltage_on, 0);
        buck_clks = 0;
        for (int p = 0; p < 50; p++) begin
            exp_w = (p < 3) ? 120 : 80;
            bad = 0;
            chk("nom_tcn", timer_cycle_num, p + 1);
            for (int c = 0; c < 200; c++) begin
                if (buck_gate !== (c < exp_w)) bad++;
                if (state == 8'h02) buck_clks++;
                tick();
            end
            chk("nom_gate_shape_bad_clocks", bad, 0);
        end
        chk("nom_buck_clocks", buck_clks, 10000);
        chk("nom_deion_state", state, 8'h80);
        chk("nom_deion_gate", buck_gate, 0);
        wait_deion(n, pd_seen);
        chk("nom_deion_clocks", n, 1000);
        chk("nom_pulse_done", pulse_done, 1);
        chk("nom_rewait_state", state, 8'h01);
        chk("nom_tcn_cleared", timer_cycle_num, 0);
        chk("nom_rewait_voltage", voltage_on, 1);

        // Open circuit: already one clock into WAIT after this tick
        tick();
        chk("nom_pulse_done_single", pulse_done, 0);
        n = 1;
        while (!open_circuit_timeout && n < 20100) begin
            tick();
            n++;
        end
        chk("oc_timeout_clocks", n, 20000);
        chk("oc_state", state, 8'h80);
        chk("oc_voltage", voltage_on, 0);
        wait_deion(n, pd_seen);
        chk("oc_deion_clocks", n, 1000);
        chk("oc_rewait_state", state, 8'h01);
        chk("oc_no_pulse_done", pd_seen, 0);

        // Breakdown, enable fall and timeout at the same edge
        oc_seen = 1'b0;
        repeat (19999) begin
            tick();
            if (open_circuit_timeout) oc_seen = 1'b1;
        end
        chk("sim_no_early_timeout", oc_seen, 0);
        chk("sim_pre_state", state, 8'h01);
        breakdown_detected = 1'b1;
        discharge_en = 1'b0;
        tick();
        breakdown_detected = 1'b0;
        chk("sim_state", state, 8'h02);
        chk("sim_no_timeout", open_circuit_timeout, 0);
        chk("sim_tcn", timer_cycle_num, 1);
        repeat (199) tick();
        chk("sim_period_full", state, 8'h02);
        tick();
        chk("sim_deion", state, 8'h80);
        wait_deion(n, pd_seen);
        chk("sim_deion_clocks", n, 1000);
        chk("sim_idle", state, 8'h00);
        chk("sim_no_pulse_done", pd_seen, 0);

        // Clamp plus disable at pc=37 of period 4
        gen_const_en = 1'b1;
        gen_const = 16'd250;
        tick();
        discharge_en = 1'b1;
        tick();
        chk("clamp_wait", state, 8'h01);
        breakdown_detected = 1'b1;
        tick();
        breakdown_detected = 1'b0;
        for (int p = 0; p < 5; p++) begin
            bad = 0;
            for (int c = 0; c < 200; c++) begin
                if (p == 4 && c == 37) discharge_en = 1'b0;
                if (buck_gate !== (c < 190)) bad++;
                if (state != 8'h02) bad++;
                tick();
            end
            chk("clamp_period_bad_clocks", bad, 0);
        end
        chk("dis_deion", state, 8'h80);
        wait_deion(n, pd_seen);
        chk("dis_deion_clocks", n, 1000);
        chk("dis_idle", state, 8'h00);
        chk("dis_no_pulse_done", pd_seen, 0);

        // Reset mid-gate
        gen_const_en = 1'b0;
        discharge_en = 1'b1;
        tick();
        tick(); tick();
        breakdown_detected = 1'b1;
        tick();
        breakdown_detected = 1'b0;
        repeat (10) tick();
        chk("rmg_gate_high", buck_gate, 1);
        rst_n = 1'b0;
        tick();
        chk("rmg_gate", buck_gate, 0);
        chk("rmg_state", state, 8'h00);
        chk("rmg_tcn", timer_cycle_num, 0);
        rst_n = 1'b1;
        tick();
        chk("rmg_release_state", state, 8'h01);
        chk("rmg_release_voltage", voltage_on, 1);

        // Zero on-time gives a fully-off period
        gen_const_en = 1'b1;
        gen_const = 16'd0;
        tick(); tick();
        breakdown_detected = 1'b1;
        tick();
        breakdown_detected = 1'b0;
        chk("zero_state", state, 8'h02);
        chk("zero_tcn", timer_cycle_num, 1);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (buck_gate !== 1'b0) bad++;
            tick();
        end
        chk("zero_gate_high_clocks", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
